d5m_frame_gen: RTL and testbench
================================

# d5m_frame_gen

Synthesizable D5M sensor emulator. It drives the same FVAL/LVAL/12-bit pixel bus that the image-processing capture path consumes. It produces complete frames of a selectable test pattern on request, so the capture, downscale and DMEM write path can be exercised without the camera, both in simulation and on the board. It sits on the GPIO1 side of the capture path, in place of the D5M pins.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (LVAL-high cycles per line), >=1
- V_ACTIVE, 480, lines per frame, >=1
- H_BLANK, 16, LVAL-low cycles between lines, >=1
- FV_LEAD, 4, cycles FVAL is high before the first LVAL, >=1
- FV_TRAIL, 8, cycles after FVAL falls before the frame counts as done, >=1

Ports:
- clk  in  1  pixel clock; all logic on its rising edge. There is one clock only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame request.
- continuous  in  1  when high, frames repeat back-to-back.
- pattern  in  2  test pattern: 0 gradient, 1 checker, 2 flat, 3 treated as flat.
- fval  out  1  frame valid.
- lval  out  1  line valid.
- d  out  12  pixel data, valid when lval is high.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_cnt  out  16  frames completed, wraps from 0xFFFF to 0.

## Operation
- All outputs are registered. On reset every output is 0 and the FSM goes to IDLE.
- FSM states: IDLE, LEAD, LINE, HBLANK, TRAIL.
- IDLE -> LEAD when start is sampled high. In the same edge:
  - pattern is latched for the whole frame;
  - row and column counters clear.
- LEAD: fval=1, lval=0 for FV_LEAD cycles, then -> LINE.
- LINE: fval=1, lval=1 for H_ACTIVE cycles. The column counter increments each cycle.
  - At end of line, if row < V_ACTIVE-1: -> HBLANK.
  - Otherwise -> TRAIL.
- HBLANK: fval=1, lval=0 for H_BLANK cycles. Row increments and column clears, then -> LINE.
- TRAIL: fval=0, lval=0, busy=1 for FV_TRAIL cycles. frame_done=1 and frame_cnt increments in the last TRAIL cycle.
  - Then, if continuous is high: -> LEAD, with pattern relatched and counters cleared.
  - Otherwise -> IDLE.
- Pixel data with lval=1 (col and row are 12 bits):
  - gradient: d = (col + row) mod 4096;
  - checker: d = 0xFFF when col[3] XOR row[3] is 1, else 0x000;
  - flat: d = 0x800.
  - d = 0 whenever lval=0.
- start while busy is ignored; requests are not queued.
- continuous is sampled only in the last TRAIL cycle. Dropping it mid-frame finishes the current frame and then returns to IDLE.
- Asserting continuous in IDLE alone does not start a frame; start is required.
- A pattern change mid-frame has no effect until the next frame start.
- rst mid-frame: at the next edge all outputs are 0 and the state is IDLE. No frame_done is generated and frame_cnt clears.

## Timing
- Take edge E0 as the edge that samples start.
  - After E0: busy=1, fval=1.
  - First lval=1 cycle: after edge E0+FV_LEAD.
- FVAL high duration: FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK cycles.
- busy duration: FVAL high duration + FV_TRAIL.
- fval falls in the same edge that lval falls after the last pixel.
- frame_done is high in the final busy cycle.
  - Non-continuous: busy drops at the following edge.
  - Continuous: fval rises again at the following edge, with no idle cycle between frames.
- Pixel-to-output latency: d and lval change together at the same edge, so there is no skew between data and strobe.

## Structure
- Package d5m_pkg holds:
  - D5M_DW = 12;
  - typedef pattern_t (PAT_GRAD, PAT_CHECK, PAT_FLAT);
  - typedef state_t for the five FSM states.
  The capture path imports the same package.
- Sub-module d5m_pixel_pattern is the combinational mapping (pattern, col, row) -> 12-bit pixel. The top module registers its output.

## Test plan
All scenarios use parameters H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, FV_LEAD=2, FV_TRAIL=3.
- Single gradient frame: start pulse, pattern=0.
  - fval high 18 cycles, busy high 21 cycles.
  - lval bursts of 4 separated by 2-cycle gaps.
  - d sequence: 0,1,2,3 / 1,2,3,4 / 2,3,4,5.
  - frame_done once; frame_cnt=1; busy=0 afterwards.
- Continuous: start with continuous=1, hold for 3 frames, then drop.
  - frame_done pulses every 21 cycles.
  - fval goes low only during each 3-cycle trail.
  - Exactly 3 frames if continuous is dropped during frame 3; frame_cnt=3.
- start during busy: a second start pulse at cycle 7.
  - Frame timing is unchanged; only one frame_done.
- Pattern latching: pattern=2 at start, then switch to 1 at cycle 5.
  - All 12 pixels are 0x800.
  - The next frame with checker gives all 0x000 (col<8 and row<8).
- Reset mid-frame: rst at cycle 10.
  - Next edge: fval=lval=busy=0, d=0, frame_cnt=0, no frame_done.
  - A subsequent start produces a full correct 21-cycle frame.
- Pattern=3: one frame; every pixel is 0x800.

Source files
------------

// File: rtl/d5m_pkg.sv
// rtl/d5m_pkg.sv - shared D5M emulator/capture types and constants
// Contents: D5M_DW pixel width, pattern_t test patterns, state_t frame FSM
// states, decode_pattern() mapping the raw 2-bit select onto pattern_t.
package d5m_pkg;

    localparam int D5M_DW = 12;

    typedef enum logic [1:0] {
        PAT_GRAD  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_FLAT  = 2'd2
    } pattern_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_TRAIL
    } state_t;

    // Select value 3 has no pattern of its own and falls back to flat.
    function automatic pattern_t decode_pattern(input logic [1:0] sel);
        case (sel)
            2'd0:    return PAT_GRAD;
            2'd1:    return PAT_CHECK;
            default: return PAT_FLAT;
        endcase
    endfunction

endpackage

// File: rtl/d5m_pixel_pattern.sv
// rtl/d5m_pixel_pattern.sv - combinational test-pattern pixel generator
// Ports:
//   pat  in  pattern_t      selected test pattern
//   col  in  D5M_DW         column index
//   row  in  D5M_DW         row index
//   pix  out D5M_DW         pixel value for (col, row)
module d5m_pixel_pattern
    import d5m_pkg::*;
(
    input  pattern_t            pat,
    input  logic [D5M_DW-1:0]   col,
    input  logic [D5M_DW-1:0]   row,
    output logic [D5M_DW-1:0]   pix
);

    localparam logic [D5M_DW-1:0] MID_GREY = {1'b1, {(D5M_DW-1){1'b0}}};

    always_comb begin
        pix = '0;
        case (pat)
            PAT_GRAD:  pix = col + row;
            // 8x8 checker squares: bit 3 toggles every 8 columns/rows.
            PAT_CHECK: pix = (col[3] ^ row[3]) ? '1 : '0;
            default:   pix = MID_GREY;
        endcase
    end

endmodule

// File: rtl/d5m_frame_gen.sv
// rtl/d5m_frame_gen.sv - D5M sensor emulator producing FVAL/LVAL/pixel frames
// Ports:
//   clk         in   pixel clock
//   rst         in   synchronous active-high reset
//   start       in   single-cycle frame request (ignored while busy)
//   continuous  in   repeat frames back-to-back, sampled at end of frame
//   pattern     in   2-bit test pattern select (0 grad, 1 checker, 2/3 flat)
//   fval        out  frame valid
//   lval        out  line valid
//   d           out  12-bit pixel, zero when lval is low
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse in the final busy cycle
//   frame_cnt   out  completed frame count, wrapping
module d5m_frame_gen
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_LEAD  = 4,
    parameter int FV_TRAIL = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [1:0]          pattern,
    output logic                fval,
    output logic                lval,
    output logic [D5M_DW-1:0]   d,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);

    localparam logic [31:0] LEAD_LAST  = 32'(FV_LEAD - 1);
    localparam logic [31:0] LINE_LAST  = 32'(H_ACTIVE - 1);
    localparam logic [31:0] HBL_LAST   = 32'(H_BLANK - 1);
    localparam logic [31:0] TRAIL_LAST = 32'(FV_TRAIL - 1);
    localparam logic [31:0] ROW_LAST   = 32'(V_ACTIVE - 1);

    state_t              state, state_n;
    logic [31:0]         cnt, cnt_n;
    logic [31:0]         row, row_n;
    logic [D5M_DW-1:0]   col, col_n;
    pattern_t            pat_q, pat_n;
    logic [D5M_DW-1:0]   pix;
    logic                last_trail_n;

    // Outputs are registered from the *next* state/counters so every output
    // describes the cycle the FSM is entering; d and lval therefore move on
    // the same edge with no skew.
    d5m_pixel_pattern u_pix (
        .pat (pat_n),
        .col (col_n),
        .row (row_n[D5M_DW-1:0]),
        .pix (pix)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        row_n   = row;
        col_n   = col;
        pat_n   = pat_q;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = ST_LEAD;
                    pat_n   = decode_pattern(pattern);
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            ST_LEAD: begin
                if (cnt == LEAD_LAST) begin
                    state_n = ST_LINE;
                    cnt_n   = '0;
                end
            end
            ST_LINE: begin
                col_n = col + 1'b1;
                if (cnt == LINE_LAST) begin
                    cnt_n   = '0;
                    state_n = (row < ROW_LAST) ? ST_HBLANK : ST_TRAIL;
                end
            end
            ST_HBLANK: begin
                if (cnt == HBL_LAST) begin
                    state_n = ST_LINE;
                    cnt_n   = '0;
                    row_n   = row + 32'd1;
                    col_n   = '0;
                end
            end
            ST_TRAIL: begin
                if (cnt == TRAIL_LAST) begin
                    cnt_n = '0;
                    if (continuous) begin
                        state_n = ST_LEAD;
                        pat_n   = decode_pattern(pattern);
                        row_n   = '0;
                        col_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        last_trail_n = (state_n == ST_TRAIL) && (cnt_n == TRAIL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            pat_q      <= PAT_GRAD;
            fval       <= 1'b0;
            lval       <= 1'b0;
            d          <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            col        <= col_n;
            pat_q      <= pat_n;
            fval       <= state_n inside {ST_LEAD, ST_LINE, ST_HBLANK};
            lval       <= (state_n == ST_LINE);
            d          <= (state_n == ST_LINE) ? pix : '0;
            busy       <= (state_n != ST_IDLE);
            frame_done <= last_trail_n;
            if (last_trail_n) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_d5m_frame_gen.sv
// tb/tb_d5m_frame_gen.sv - self-checking bench for d5m_frame_gen
module tb_d5m_frame_gen;

    localparam int HA = 4;
    localparam int VA = 3;
    localparam int HB = 2;
    localparam int FL = 2;
    localparam int FT = 3;
    localparam int FV_LEN = FL + VA * HA + (VA - 1) * HB;
    localparam int TOT    = FV_LEN + FT;

    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [1:0]  pattern;
    logic        fval;
    logic        lval;
    logic [11:0] d;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    d5m_frame_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .FV_LEAD  (FL),
        .FV_TRAIL (FT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .pattern    (pattern),
        .fval       (fval),
        .lval       (lval),
        .d          (d),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame model: m_t is the cycle index within the current frame,
    // 0 being the cycle right after the edge that accepted the frame.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [1:0]  m_pat    = 2'd0;
    int          m_cnt    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_pat    = pattern;
            end
        end else if (m_t == TOT - 1) begin
            if (continuous) begin
                m_t   = 0;
                m_pat = pattern;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == TOT - 1) m_cnt = (m_cnt + 1) % 65536;
        end
    end

    function automatic int exp_pix(input logic [1:0] p, input int c, input int r);
        if (p == 2'd0) return (c + r) % 4096;
        if (p == 2'd1) return (((c / 8) % 2) != ((r / 8) % 2)) ? 4095 : 0;
        return 2048;
    endfunction

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int fval_tot = 0, busy_tot = 0, done_tot = 0, trail_tot = 0;
    int pix_q[$];
    int done_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        int e_fv, e_lv, e_bz, e_fd, e_d, u;
        e_fv = 0; e_lv = 0; e_bz = 0; e_fd = 0; e_d = 0;
        if (m_active) begin
            e_bz = 1;
            e_fv = (m_t < FV_LEN) ? 1 : 0;
            e_fd = (m_t == TOT - 1) ? 1 : 0;
            u = m_t - FL;
            if (u >= 0 && u < FV_LEN - FL && (u % (HA + HB)) < HA) begin
                e_lv = 1;
                e_d  = exp_pix(m_pat, u % (HA + HB), u / (HA + HB));
            end
        end
        chk("fval", int'(fval), e_fv);
        chk("lval", int'(lval), e_lv);
        chk("d", int'(d), e_d);
        chk("busy", int'(busy), e_bz);
        chk("frame_done", int'(frame_done), e_fd);
        chk("frame_cnt", int'(frame_cnt), m_cnt);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare();
        if (fval) fval_tot++;
        if (busy) busy_tot++;
        if (busy && !fval) trail_tot++;
        if (lval) pix_q.push_back(int'(d));
        if (frame_done) begin
            done_tot++;
            done_q.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", (n < 300) ? 1 : 0, 1);
        tick();
        tick();
    endtask

    task automatic chk_pixels(input string name, input int base, input int val);
        chk({name, "_count"}, pix_q.size() - base, HA * VA);
        for (int i = base; i < pix_q.size(); i++) chk(name, pix_q[i], val);
    endtask

    int grad_exp[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
    int b_fv, b_bz, b_dn, b_tr, b_px, n;

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; pattern = 2'd0;
        tick();
        tick();
        chk("rst_fval", int'(fval), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        tick();

        // Continuous alone must not start a frame.
        continuous = 1'b1;
        repeat (4) tick();
        chk("cont_no_start_busy", int'(busy), 0);
        continuous = 1'b0;
        tick();

        // Single gradient frame.
        b_fv = fval_tot; b_bz = busy_tot; b_dn = done_tot; b_px = pix_q.size();
        pattern = 2'd0;
        pulse_start();
        wait_idle();
        chk("grad_fval_cycles", fval_tot - b_fv, 18);
        chk("grad_busy_cycles", busy_tot - b_bz, 21);
        chk("grad_done", done_tot - b_dn, 1);
        chk("grad_frame_cnt", int'(frame_cnt), 1);
        chk("grad_pix_count", pix_q.size() - b_px, 12);
        if (pix_q.size() - b_px == 12)
            for (int i = 0; i < 12; i++) chk("grad_pix", pix_q[b_px + i], grad_exp[i]);

        // Continuous: three frames, dropped during the third.
        do_reset();
        b_fv = fval_tot; b_dn = done_tot; b_tr = trail_tot;
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (done_tot - b_dn < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("cont_wait_bound", (n < 200) ? 1 : 0, 1);
        repeat (5) tick();
        continuous = 1'b0;
        wait_idle();
        chk("cont_done", done_tot - b_dn, 3);
        chk("cont_frame_cnt", int'(frame_cnt), 3);
        chk("cont_fval_cycles", fval_tot - b_fv, 54);
        chk("cont_trail_cycles", trail_tot - b_tr, 9);
        if (done_q.size() >= 3) begin
            chk("cont_done_gap1", done_q[done_q.size()-2] - done_q[done_q.size()-3], 21);
            chk("cont_done_gap2", done_q[done_q.size()-1] - done_q[done_q.size()-2], 21);
        end

        // Second start while busy is ignored.
        do_reset();
        b_bz = busy_tot; b_dn = done_tot;
        pulse_start();
        repeat (6) tick();
        pulse_start();
        wait_idle();
        chk("busy_start_cycles", busy_tot - b_bz, 21);
        chk("busy_start_done", done_tot - b_dn, 1);
        chk("busy_start_frame_cnt", int'(frame_cnt), 1);

        // Pattern latched at start: flat, then checker for the next frame.
        do_reset();
        b_px = pix_q.size();
        pattern = 2'd2;
        pulse_start();
        repeat (4) tick();
        pattern = 2'd1;
        wait_idle();
        chk_pixels("flat_latched", b_px, 2048);
        b_px = pix_q.size();
        pulse_start();
        wait_idle();
        chk_pixels("checker_dark", b_px, 0);

        // Reset mid-frame.
        do_reset();
        b_dn = done_tot;
        pattern = 2'd0;
        pulse_start();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("midrst_fval", int'(fval), 0);
        chk("midrst_lval", int'(lval), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_d", int'(d), 0);
        chk("midrst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_no_done", done_tot - b_dn, 0);
        b_bz = busy_tot; b_dn = done_tot; b_px = pix_q.size();
        pulse_start();
        wait_idle();
        chk("midrst_busy_cycles", busy_tot - b_bz, 21);
        chk("midrst_done", done_tot - b_dn, 1);
        chk("midrst_frame_cnt_after", int'(frame_cnt), 1);
        if (pix_q.size() - b_px == 12)
            for (int i = 0; i < 12; i++) chk("midrst_pix", pix_q[b_px + i], grad_exp[i]);

        // Pattern select 3 behaves as flat.
        b_px = pix_q.size();
        pattern = 2'd3;
        pulse_start();
        wait_idle();
        chk_pixels("pat3_flat", b_px, 2048);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
